// File: rtl/fan_demux.sv
// Registered 1-to-LANES write demultiplexer: each lane keeps its last written value,
// and every write raises a one-cycle strobe for the lanes it touched.
module fan_demux #(
    parameter int                      SIGNAL_WIDTH = 8,
    parameter int                      SEL_WIDTH    = 3,
    parameter logic [SIGNAL_WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      en,
    input  logic [1:0]                                mode,
    input  logic [SEL_WIDTH-1:0]                      selector,
    input  logic [SIGNAL_WIDTH-1:0]                   in,
    output logic [(2**SEL_WIDTH)*SIGNAL_WIDTH-1:0]    out,
    output logic [(2**SEL_WIDTH)-1:0]                 strobe,
    output logic [SEL_WIDTH-1:0]                      last_sel,
    output logic [7:0]                                wr_count
);

    localparam int LANES = 2**SEL_WIDTH;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_CLEAR = 2'b01,
        MODE_BCAST = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    logic [LANES-1:0][SIGNAL_WIDTH-1:0] lanes_q, lanes_d;
    logic [LANES-1:0]                   strobe_q, strobe_d;
    logic [SEL_WIDTH-1:0]               last_sel_q, last_sel_d;
    logic [7:0]                         wr_count_q, wr_count_d;

    // en is a plain write enable: every edge with en high is accepted, there is no backpressure.
    always_comb begin
        lanes_d    = lanes_q;
        strobe_d   = '0;
        last_sel_d = last_sel_q;
        wr_count_d = wr_count_q;
        if (en) begin
            last_sel_d = selector;
            wr_count_d = wr_count_q + 8'd1;
            case (mode_e'(mode))
                MODE_BCAST: begin
                    lanes_d  = {LANES{in}};
                    strobe_d = '1;
                end
                MODE_CLEAR: begin
                    lanes_d           = '0;
                    lanes_d[selector] = in;
                    strobe_d[selector] = 1'b1;
                end
                default: begin
                    lanes_d[selector]  = in;
                    strobe_d[selector] = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q    <= {LANES{RESET_VALUE}};
            strobe_q   <= '0;
            last_sel_q <= '0;
            wr_count_q <= '0;
        end else begin
            lanes_q    <= lanes_d;
            strobe_q   <= strobe_d;
            last_sel_q <= last_sel_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign out      = lanes_q;
    assign strobe   = strobe_q;
    assign last_sel = last_sel_q;
    assign wr_count = wr_count_q;

endmodule
